// File: rtl/cue_shot_controller.sv
// Cue-ball shot generator.
// Waits for the ball to settle, lets the player steer a 16-step aim and charge
// power on frame ticks, then emits one velocity impulse qualified by shotValid.
module cue_shot_controller #(
  parameter int AIM_RATE     = 4,
  parameter int STOP_FRAMES  = 8,
  parameter int MOVE_TIMEOUT = 16,
  parameter int MAX_POWER    = 63
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               keyLeft,
  input  logic               keyRight,
  input  logic               keyShoot,
  input  logic signed [10:0] ballVelocityX,
  input  logic signed [10:0] ballVelocityY,
  output logic signed [10:0] velocityX,
  output logic signed [10:0] velocityY,
  output logic               shotValid,
  output logic signed [7:0]  aimDirX,
  output logic signed [7:0]  aimDirY,
  output logic [5:0]         power,
  output logic               aiming
);

  localparam int DATA_W = 11;
  localparam int COEF_W = 8;
  localparam int PWR_W  = 6;
  localparam int PROD_W = 14;
  localparam int CNT_W  = 16;

  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_FRAMES - 1);
  localparam logic [CNT_W-1:0] AIM_LAST  = CNT_W'(AIM_RATE - 1);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TIMEOUT - 1);
  localparam logic [PWR_W-1:0] PWR_MAX   = PWR_W'(MAX_POWER);

  typedef enum logic [2:0] {
    WAIT_STOP,
    AIM,
    CHARGE,
    FIRE,
    WAIT_MOVE
  } state_t;

  // Cosine scaled by 64; the upper half of the circle mirrors the lower half.
  function automatic logic signed [COEF_W-1:0] cos_lut(input logic [3:0] a);
    logic [3:0] m;
    m = (a > 4'd8) ? (4'd0 - a) : a;
    case (m)
      4'd0:    cos_lut = 8'sd64;
      4'd1:    cos_lut = 8'sd59;
      4'd2:    cos_lut = 8'sd45;
      4'd3:    cos_lut = 8'sd24;
      4'd4:    cos_lut = 8'sd0;
      4'd5:    cos_lut = -8'sd24;
      4'd6:    cos_lut = -8'sd45;
      4'd7:    cos_lut = -8'sd59;
      default: cos_lut = -8'sd64;
    endcase
  endfunction

  // Direction times power divided by 32, flooring toward minus infinity.
  function automatic logic signed [DATA_W-1:0] scale_shot(
    input logic signed [COEF_W-1:0] dir,
    input logic [PWR_W-1:0]         pwr
  );
    logic signed [PROD_W-1:0] dir_w;
    logic signed [PROD_W-1:0] pwr_w;
    logic signed [PROD_W-1:0] prod;
    dir_w = {{(PROD_W-COEF_W){dir[COEF_W-1]}}, dir};
    pwr_w = {{(PROD_W-PWR_W){1'b0}}, pwr};
    prod  = dir_w * pwr_w;
    prod  = prod >>> 5;
    scale_shot = prod[DATA_W-1:0];
  endfunction

  // Power charge step that sticks at the ceiling.
  function automatic logic [PWR_W-1:0] sat_inc_power(input logic [PWR_W-1:0] pwr);
    sat_inc_power = (pwr >= PWR_MAX) ? PWR_MAX : pwr + PWR_W'(1);
  endfunction

  state_t             state, state_next;
  logic [CNT_W-1:0]   stop_cnt, stop_cnt_next;
  logic [CNT_W-1:0]   aim_cnt, aim_cnt_next;
  logic [CNT_W-1:0]   move_cnt, move_cnt_next;
  logic [3:0]         angle, angle_next;
  logic [PWR_W-1:0]   power_next;
  logic               latch_shot;
  logic               ball_still;
  logic signed [DATA_W-1:0] vel_x_p1;
  logic signed [DATA_W-1:0] vel_y_p1;

  assign ball_still = (ballVelocityX == '0) && (ballVelocityY == '0);

  // Next-state, counter, angle and power decisions; all keyed on the frame tick.
  always_comb begin
    state_next    = state;
    stop_cnt_next = stop_cnt;
    aim_cnt_next  = aim_cnt;
    move_cnt_next = move_cnt;
    angle_next    = angle;
    power_next    = power;
    latch_shot    = 1'b0;
    unique case (state)
      WAIT_STOP: begin
        if (startOfFrame) begin
          if (!ball_still) begin
            stop_cnt_next = '0;
          end else if (stop_cnt == STOP_LAST) begin
            stop_cnt_next = '0;
            state_next    = AIM;
          end else begin
            stop_cnt_next = stop_cnt + CNT_W'(1);
          end
        end
      end
      AIM: begin
        if (startOfFrame) begin
          if (keyShoot) begin
            state_next   = CHARGE;
            power_next   = '0;
            aim_cnt_next = '0;
          end else if (keyLeft ^ keyRight) begin
            if (aim_cnt == AIM_LAST) begin
              aim_cnt_next = '0;
              angle_next   = keyRight ? angle + 4'd1 : angle - 4'd1;
            end else begin
              aim_cnt_next = aim_cnt + CNT_W'(1);
            end
          end else begin
            aim_cnt_next = '0;
          end
        end
      end
      CHARGE: begin
        if (startOfFrame) begin
          if (keyShoot) begin
            power_next = sat_inc_power(power);
          end else if (power != '0) begin
            state_next = FIRE;
            latch_shot = 1'b1;
          end else begin
            state_next = AIM;
          end
        end
      end
      FIRE: begin
        state_next = WAIT_MOVE;
        power_next = '0;
      end
      WAIT_MOVE: begin
        if (startOfFrame) begin
          if (!ball_still || (move_cnt == MOVE_LAST)) begin
            move_cnt_next = '0;
            state_next    = WAIT_STOP;
          end else begin
            move_cnt_next = move_cnt + CNT_W'(1);
          end
        end
      end
      default: state_next = WAIT_STOP;
    endcase
  end

  // Control registers, including the registered aim direction that trails the angle by one clock.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state    <= WAIT_STOP;
      stop_cnt <= '0;
      aim_cnt  <= '0;
      move_cnt <= '0;
      angle    <= '0;
      power    <= '0;
      aimDirX  <= 8'sd64;
      aimDirY  <= 8'sd0;
    end else begin
      state    <= state_next;
      stop_cnt <= stop_cnt_next;
      aim_cnt  <= aim_cnt_next;
      move_cnt <= move_cnt_next;
      angle    <= angle_next;
      power    <= power_next;
      aimDirX  <= cos_lut(angle);
      aimDirY  <= cos_lut(angle - 4'd4);
    end
  end

  // Stage p1: shot product captured on the release frame, presented during FIRE.
  always_ff @(posedge clk) begin
    if (latch_shot) begin
      vel_x_p1 <= scale_shot(aimDirX, power);
      vel_y_p1 <= scale_shot(aimDirY, power);
    end
  end

  assign shotValid = (state == FIRE);
  assign velocityX = shotValid ? vel_x_p1 : '0;
  assign velocityY = shotValid ? vel_y_p1 : '0;
  assign aiming    = (state == AIM) || (state == CHARGE);

endmodule

// File: tb/tb_cue_shot_controller.sv
// Bench for cue_shot_controller: frame-level reference model checked every
// clock, plus hand-computed literal expectations along a directed sequence.
module tb_cue_shot_controller;

  localparam int AIM_RATE     = 4;
  localparam int STOP_FRAMES  = 8;
  localparam int MOVE_TIMEOUT = 16;
  localparam int MAX_POWER    = 63;

  localparam int P_SETTLE = 0;
  localparam int P_AIM    = 1;
  localparam int P_CHARGE = 2;
  localparam int P_SHOT   = 3;
  localparam int P_DRIFT  = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic sof = 1'b0;
  logic kl = 1'b0, kr = 1'b0, ks = 1'b0;
  logic signed [10:0] bvx = '0, bvy = '0;
  logic signed [10:0] velocityX, velocityY;
  logic shotValid;
  logic signed [7:0] aimDirX, aimDirY;
  logic [5:0] power;
  logic aiming;

  int vectors = 0;
  int miscompares = 0;

  cue_shot_controller #(
    .AIM_RATE(AIM_RATE), .STOP_FRAMES(STOP_FRAMES),
    .MOVE_TIMEOUT(MOVE_TIMEOUT), .MAX_POWER(MAX_POWER)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof),
    .keyLeft(kl), .keyRight(kr), .keyShoot(ks),
    .ballVelocityX(bvx), .ballVelocityY(bvy),
    .velocityX(velocityX), .velocityY(velocityY), .shotValid(shotValid),
    .aimDirX(aimDirX), .aimDirY(aimDirY), .power(power), .aiming(aiming)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int costab[9] = '{64, 59, 45, 24, 0, -24, -45, -59, -64};

  function automatic int mcos(input int a);
    int i;
    i = ((a % 16) + 16) % 16;
    if (i > 8) i = 16 - i;
    return costab[i];
  endfunction

  function automatic int floor_div32(input int p);
    if (p >= 0) return p / 32;
    return -((-p + 31) / 32);
  endfunction

  bit mvalid = 1'b0;
  int m_phase, m_angle, m_power, m_cnt, m_hold, m_dx, m_dy, m_vx, m_vy;

  always @(posedge clk) begin
    if (!resetN) begin
      mvalid  = 1'b1;
      m_phase = P_SETTLE;
      m_angle = 0; m_power = 0; m_cnt = 0; m_hold = 0;
      m_dx = 64; m_dy = 0; m_vx = 0; m_vy = 0;
    end else if (mvalid) begin
      m_dx = mcos(m_angle);
      m_dy = mcos(m_angle - 4);
      if (m_phase == P_SHOT) begin
        m_phase = P_DRIFT; m_power = 0; m_cnt = 0;
      end else if (sof) begin
        case (m_phase)
          P_SETTLE: begin
            if (bvx == 0 && bvy == 0) begin
              m_cnt++;
              if (m_cnt == STOP_FRAMES) begin m_phase = P_AIM; m_cnt = 0; end
            end else m_cnt = 0;
          end
          P_AIM: begin
            if (ks) begin
              m_phase = P_CHARGE; m_power = 0; m_hold = 0;
            end else if (kl != kr) begin
              m_hold++;
              if (m_hold == AIM_RATE) begin
                m_angle = (m_angle + (kr ? 1 : 15)) % 16;
                m_hold = 0;
              end
            end else m_hold = 0;
          end
          P_CHARGE: begin
            if (ks) begin
              if (m_power < MAX_POWER) m_power++;
            end else if (m_power > 0) begin
              m_phase = P_SHOT;
              m_vx = floor_div32(mcos(m_angle) * m_power);
              m_vy = floor_div32(mcos(m_angle - 4) * m_power);
            end else m_phase = P_AIM;
          end
          default: begin
            if (bvx != 0 || bvy != 0) begin
              m_phase = P_SETTLE; m_cnt = 0;
            end else begin
              m_cnt++;
              if (m_cnt == MOVE_TIMEOUT) begin m_phase = P_SETTLE; m_cnt = 0; end
            end
          end
        endcase
      end
    end
  end

  // Every clock, away from the active edge, compare all outputs against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_shotValid", shotValid, (m_phase == P_SHOT) ? 1 : 0);
      chk("m_velocityX", velocityX, (m_phase == P_SHOT) ? m_vx : 0);
      chk("m_velocityY", velocityY, (m_phase == P_SHOT) ? m_vy : 0);
      chk("m_aiming", aiming, (m_phase == P_AIM || m_phase == P_CHARGE) ? 1 : 0);
      chk("m_aimDirX", aimDirX, m_dx);
      chk("m_aimDirY", aimDirY, m_dy);
      chk("m_power", power, m_power);
    end
  end

  // ---------------- stimulus ----------------
  task automatic frame(input logic l, input logic r, input logic s, input int vx, input int vy);
    @(posedge clk); #1;
    kl = l; kr = r; ks = s;
    bvx = 11'(vx); bvy = 11'(vy);
    sof = 1'b1;
    @(posedge clk); #1;
    sof = 1'b0;
  endtask

  task automatic frames(input int n, input logic l = 1'b0, input logic r = 1'b0, input logic s = 1'b0);
    for (int i = 0; i < n; i++) frame(l, r, s, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetN = 1'b0; sof = 1'b0; kl = 1'b0; kr = 1'b0; ks = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
  endtask

  initial begin
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    #1;
    chk("rst_aiming", aiming, 0);
    chk("rst_aimDirX", aimDirX, 64);
    chk("rst_aimDirY", aimDirY, 0);
    chk("rst_power", power, 0);
    chk("rst_shotValid", shotValid, 0);

    // Ball at rest: AIM on the eighth frame.
    frames(7); #1 chk("settle7_aiming", aiming, 0);
    frames(1); #1 chk("settle8_aiming", aiming, 1);
    chk("settle8_aimDirX", aimDirX, 64);

    // Movement on frame 5 restarts the stop count.
    do_reset();
    frames(4);
    frame(1'b0, 1'b0, 1'b0, 3, 0);
    frames(7); #1 chk("restart7_aiming", aiming, 0);
    frames(1); #1 chk("restart8_aiming", aiming, 1);

    // Angle 0, power 32: velocity (64,0).
    frame(1'b0, 1'b0, 1'b1, 0, 0);
    frames(32, 1'b0, 1'b0, 1'b1); #1 chk("charge32_power", power, 32);
    frame(1'b0, 1'b0, 1'b0, 0, 0); #1;
    chk("shot1_valid", shotValid, 1);
    chk("shot1_vx", velocityX, 64);
    chk("shot1_vy", velocityY, 0);
    @(posedge clk); #2;
    chk("shot1_after_valid", shotValid, 0);
    chk("shot1_after_power", power, 0);
    chk("shot1_after_aiming", aiming, 0);

    // Ball never moves: 16-frame timeout, then 8 frames to settle.
    frames(16); #1 chk("timeout_aiming", aiming, 0);
    frames(7);  #1 chk("timeout_settle7", aiming, 0);
    frames(1);  #1 chk("timeout_settle8", aiming, 1);

    // Right 8 frames: angle 2.
    frames(8, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("ang2_aimDirX", aimDirX, 45);
    chk("ang2_aimDirY", aimDirY, 45);
    frame(1'b0, 1'b0, 1'b1, 0, 0);
    frames(70, 1'b0, 1'b0, 1'b1); #1 chk("sat_power", power, 63);
    frame(1'b0, 1'b0, 1'b0, 0, 0); #1;
    chk("shot2_vx", velocityX, 88);
    chk("shot2_vy", velocityY, 88);

    // Ball starts moving right away, then settles.
    frame(1'b0, 1'b0, 1'b0, 5, -2);
    frames(7); #1 chk("moved_settle7", aiming, 0);
    frames(1); #1 chk("moved_settle8", aiming, 1);

    // Right 32 more frames: angle 10.
    frames(32, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("ang10_aimDirX", aimDirX, -45);
    chk("ang10_aimDirY", aimDirY, -45);
    frame(1'b0, 1'b0, 1'b1, 0, 0);
    frames(63, 1'b0, 1'b0, 1'b1);
    frame(1'b0, 1'b0, 1'b0, 0, 0); #1;
    chk("shot3_vx", velocityX, -89);
    chk("shot3_vy", velocityY, -89);

    // Left from angle 0 wraps to 15.
    do_reset();
    frames(8);
    frames(4, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("wrap_aimDirX", aimDirX, 59);
    chk("wrap_aimDirY", aimDirY, -24);

    // Both keys held: no rotation.
    frames(8, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #2 chk("both_aimDirX", aimDirX, 59);

    // A released frame clears the hold count.
    frames(3, 1'b1, 1'b0, 1'b0);
    frames(1);
    frames(3, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2 chk("gap_aimDirX", aimDirX, 59);

    // Press and release with zero power: back to AIM, no shot.
    frame(1'b0, 1'b0, 1'b1, 0, 0);
    frame(1'b0, 1'b0, 1'b0, 0, 0); #1;
    chk("zero_pwr_valid", shotValid, 0);
    chk("zero_pwr_aiming", aiming, 1);
    @(posedge clk); #2 chk("zero_pwr_valid_next", shotValid, 0);

    // Reset asserted over the release frame mid-charge.
    frame(1'b0, 1'b0, 1'b1, 0, 0);
    frames(10, 1'b0, 1'b0, 1'b1); #1 chk("midcharge_power", power, 10);
    resetN = 1'b0;
    frame(1'b0, 1'b0, 1'b0, 0, 0); #1;
    chk("rstcharge_valid", shotValid, 0);
    chk("rstcharge_power", power, 0);
    chk("rstcharge_aiming", aiming, 0);
    chk("rstcharge_aimDirX", aimDirX, 64);
    resetN = 1'b1;
    @(posedge clk); #2 chk("rstcharge_valid_next", shotValid, 0);
    frames(8); #1 chk("rstcharge_settle", aiming, 1);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
